calc_arbiter: RTL and testbench

CALC_ARBITER -- requirements
Module: calc_arbiter

---
 rtl/calc_pkg.sv | 19 +
 rtl/calc_arbiter_rr.sv | 25 ++
 rtl/calc_arbiter.sv | 94 +++++++++
 tb/tb_calc_arbiter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator arbiter: opcodes, datapath widths and
// the default calculator latency.
package calc_pkg;
    typedef enum logic [1:0] {
        OP_SUM = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } calc_op_e;

    localparam int OPND_W       = 8;
    localparam int RES_W        = 16;
    localparam int CALC_LAT_DEF = 2;

    // Index width for an n-entry vector; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/calc_arbiter_rr.sv
// Round-robin grant: picks the first requester at or after ptr, wrapping to 0.
// Purely combinational; the caller owns the pointer register.
module rr_arbiter
    import calc_pkg::*;
#(
    parameter int N     = 4,
    parameter int PTR_W = idx_w(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant
);

    logic [N-1:0] mask;
    logic [N-1:0] req_hi;

    // Requests at or above ptr win first; the lowest set bit is isolated with x & -x.
    always_comb begin
        mask   = ~((N'(1) << ptr) - N'(1));
        req_hi = req & mask;
        if (|req_hi) grant = req_hi & (~req_hi + N'(1));
        else         grant = req & (~req + N'(1));
    end

endmodule

// File: rtl/calc_arbiter.sv
// Shares one external pipelined calculator between NUM_REQ requesters and
// routes each registered result back to its owner CALC_LAT cycles later.
module calc_arbiter
    import calc_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int CALC_LAT = CALC_LAT_DEF
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             arb_en,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ-1:0][1:0]          req_func,
    input  logic [NUM_REQ-1:0][OPND_W-1:0]   req_a,
    input  logic [NUM_REQ-1:0][OPND_W-1:0]   req_b,
    output logic [NUM_REQ-1:0]               req_ready,
    output logic [1:0]                       calc_function,
    output logic [OPND_W-1:0]                calc_dat_a,
    output logic [OPND_W-1:0]                calc_dat_b,
    input  logic signed [RES_W-1:0]          calc_out,
    output logic [NUM_REQ-1:0]               resp_valid,
    output logic signed [RES_W-1:0]          resp_data,
    output logic                             idle
);

    localparam int PTR_W = idx_w(NUM_REQ);

    logic [PTR_W-1:0]              rr_ptr_q, rr_ptr_d;
    logic                          run_q;
    logic [CALC_LAT:1]             vld_pipe_q;
    logic [CALC_LAT:1][PTR_W-1:0]  own_pipe_q;
    logic [NUM_REQ-1:0]            grant;
    logic [PTR_W-1:0]              gnt_idx;
    logic                          xfer;

    rr_arbiter #(.N(NUM_REQ), .PTR_W(PTR_W)) u_rr (
        .req   (req_valid),
        .ptr   (rr_ptr_q),
        .grant (grant)
    );

    // run_q holds grants off until the first edge after reset release.
    assign req_ready = grant & {NUM_REQ{arb_en & run_q}};
    assign xfer      = |req_ready;

    always_comb begin
        gnt_idx       = '0;
        calc_function = '0;
        calc_dat_a    = '0;
        calc_dat_b    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i]) begin
                gnt_idx       = PTR_W'(i);
                calc_function = req_func[i];
                calc_dat_a    = req_a[i];
                calc_dat_b    = req_b[i];
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (xfer)
            rr_ptr_d = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q   <= '0;
            run_q      <= 1'b0;
            vld_pipe_q <= '0;
            own_pipe_q <= '0;
        end else begin
            rr_ptr_q      <= rr_ptr_d;
            run_q         <= 1'b1;
            vld_pipe_q[1] <= xfer;
            own_pipe_q[1] <= gnt_idx;
            for (int k = 2; k <= CALC_LAT; k++) begin
                vld_pipe_q[k] <= vld_pipe_q[k-1];
                own_pipe_q[k] <= own_pipe_q[k-1];
            end
        end
    end

    // The last pipe stage lines up with the calculator's registered result.
    always_comb begin
        resp_valid = '0;
        if (vld_pipe_q[CALC_LAT]) resp_valid[own_pipe_q[CALC_LAT]] = 1'b1;
    end

    assign resp_data = vld_pipe_q[CALC_LAT] ? calc_out : '0;
    assign idle      = ~xfer & ~(|vld_pipe_q);

endmodule

// File: tb/tb_calc_arbiter.sv
// Directed plus randomized bench for calc_arbiter with a behavioural
// two-stage calculator and a queue-based response model.
module tb_calc_arbiter;
    import calc_pkg::*;

    localparam int N   = 4;
    localparam int LAT = 2;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    arb_en;
    logic [N-1:0]            req_valid;
    logic [N-1:0][1:0]       req_func;
    logic [N-1:0][7:0]       req_a, req_b;
    logic [N-1:0]            req_ready, resp_valid;
    logic [1:0]              calc_function;
    logic [7:0]              calc_dat_a, calc_dat_b;
    logic signed [15:0]      calc_out, calc_s1, resp_data;
    logic                    idle;

    calc_arbiter #(.NUM_REQ(N), .CALC_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .arb_en(arb_en),
        .req_valid(req_valid), .req_func(req_func), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .calc_function(calc_function),
        .calc_dat_a(calc_dat_a), .calc_dat_b(calc_dat_b), .calc_out(calc_out),
        .resp_valid(resp_valid), .resp_data(resp_data), .idle(idle)
    );

    always #5 clk = ~clk;

    function automatic int ref_calc(input int fn, input int a, input int b);
        case (fn)
            0: return a + b;
            1: return a - b;
            2: return a * b;
            default: return (b == 0) ? ((a < 0) ? -32768 : 32767) : a / b;
        endcase
    endfunction

    // Calculator with CALC_LAT = 2 register stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            calc_s1  <= '0;
            calc_out <= '0;
        end else begin
            calc_s1  <= 16'(ref_calc(int'(calc_function), int'($signed(calc_dat_a)),
                                     int'($signed(calc_dat_b))));
            calc_out <= calc_s1;
        end
    end

    typedef struct { int due; int own; int data; } exp_t;
    exp_t               q[$];
    int                 m_ptr, cyc, npass, ntot;
    bit                 m_run;
    string              phase;
    logic [N-1:0]       obs_rv;
    logic signed [15:0] obs_rd;
    logic               obs_idle;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s/%s: got %0h expected %0h", phase, tag, obs, exp);
    endtask

    task automatic set_req(input int i, input int fn, input int a, input int b);
        req_valid[i] = 1'b1;
        req_func[i]  = 2'(fn);
        req_a[i]     = 8'(a);
        req_b[i]     = 8'(b);
    endtask

    // One cycle: predict and check at the falling edge, advance the model at the rising edge.
    task automatic step();
        int g, edata;
        logic [N-1:0] erv;
        @(negedge clk);
        g = -1;
        if (m_run && arb_en && rst_n)
            for (int k = 0; k < N; k++) begin
                int i;
                i = (m_ptr + k) % N;
                if (g < 0 && req_valid[i]) g = i;
            end
        if (g < 0) begin
            chk("req_ready", {28'd0, req_ready}, 0);
            chk("calc_function", {30'd0, calc_function}, 0);
            chk("calc_dat_a", {24'd0, calc_dat_a}, 0);
            chk("calc_dat_b", {24'd0, calc_dat_b}, 0);
        end else begin
            chk("req_ready", {28'd0, req_ready}, 32'(1 << g));
            chk("calc_function", {30'd0, calc_function}, {30'd0, req_func[g]});
            chk("calc_dat_a", {24'd0, calc_dat_a}, {24'd0, req_a[g]});
            chk("calc_dat_b", {24'd0, calc_dat_b}, {24'd0, req_b[g]});
        end
        erv = '0;
        edata = 0;
        if (q.size() > 0 && q[0].due == cyc) begin
            erv[q[0].own] = 1'b1;
            edata = q[0].data;
        end
        chk("resp_valid", {28'd0, resp_valid}, {28'd0, erv});
        if (erv != 0) chk("resp_data", resp_data, edata);
        chk("idle", {31'd0, idle}, {31'd0, (g < 0 && q.size() == 0)});
        obs_rv   = resp_valid;
        obs_rd   = resp_data;
        obs_idle = idle;
        if (erv != 0) q.delete(0);
        @(posedge clk);
        if (g >= 0) begin
            q.push_back('{cyc + LAT, g, ref_calc(int'(req_func[g]), int'($signed(req_a[g])),
                                                 int'($signed(req_b[g])))});
            m_ptr = (g + 1) % N;
        end
        cyc++;
        m_run = rst_n;
        #1;
        if (g >= 0) req_valid[g] = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_req_ready", {28'd0, req_ready}, 0);
        chk("rst_resp_valid", {28'd0, resp_valid}, 0);
        chk("rst_resp_data", {16'd0, resp_data}, 0);
        chk("rst_calc_function", {30'd0, calc_function}, 0);
        chk("rst_calc_dat_a", {24'd0, calc_dat_a}, 0);
        chk("rst_calc_dat_b", {24'd0, calc_dat_b}, 0);
        chk("rst_idle", {31'd0, idle}, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        q.delete();
        m_ptr = 0;
        m_run = 1'b0;
    endtask

    initial begin
        npass = 0; ntot = 0; cyc = 0; m_ptr = 0; m_run = 1'b0;
        req_valid = '0; req_func = '0; req_a = '0; req_b = '0;
        arb_en = 1'b1;

        // All four valid through reset: nothing granted before the first live edge.
        phase = "contention";
        set_req(0, OP_SUM, 10, 20);
        set_req(1, OP_SUB, -5, 7);
        set_req(2, OP_MUL, 12, -3);
        set_req(3, OP_DIV, 100, 7);
        do_reset();
        repeat (8) step();

        phase = "single_sum";
        set_req(0, OP_SUM, 5, 3);
        repeat (3) step();
        chk("sum_valid", {28'd0, obs_rv}, 32'h1);
        chk("sum_data", obs_rd, 8);
        step();

        phase = "wrap";
        set_req(2, OP_SUB, 50, 60);
        step();
        set_req(0, OP_SUM, 1, 2);
        set_req(3, OP_MUL, 7, 9);
        repeat (5) step();

        phase = "div_mul";
        set_req(1, OP_DIV, -100, 0);
        repeat (3) step();
        chk("div0_valid", {28'd0, obs_rv}, 32'h2);
        chk("div0_data", obs_rd, -32768);
        set_req(1, OP_MUL, -128, -128);
        repeat (3) step();
        chk("mul_valid", {28'd0, obs_rv}, 32'h2);
        chk("mul_data", obs_rd, 16384);
        step();

        phase = "reset_mid";
        set_req(2, OP_SUM, 1, 1);
        repeat (2) step();
        do_reset();
        set_req(3, OP_SUM, 3, 3);
        set_req(0, OP_SUM, 4, 4);
        repeat (6) step();
        chk("rst_mid_idle", {31'd0, obs_idle}, 1);

        phase = "arb_en_drop";
        set_req(0, OP_SUB, 9, 4);
        set_req(1, OP_MUL, -6, 5);
        repeat (2) step();
        arb_en = 1'b0;
        set_req(2, OP_SUM, 1, 1);
        set_req(3, OP_DIV, 9, 3);
        repeat (4) step();
        chk("drop_idle", {31'd0, obs_idle}, 1);
        chk("drop_held", {28'd0, req_valid}, 32'hC);
        arb_en = 1'b1;
        repeat (6) step();

        phase = "random";
        for (int n = 0; n < 400; n++) begin
            arb_en = ($urandom_range(0, 9) != 0);
            for (int i = 0; i < N; i++)
                if (!req_valid[i] && $urandom_range(0, 1) == 1)
                    set_req(i, int'($urandom_range(0, 3)), int'($signed(8'($urandom_range(0, 255)))),
                            ($urandom_range(0, 7) == 0) ? 0
                                : int'($signed(8'($urandom_range(0, 255)))));
            if (n == 200) do_reset();
            step();
        end
        arb_en = 1'b1;
        repeat (10) step();
        chk("final_idle", {31'd0, obs_idle}, 1);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
